// File: rtl/tmr_error_monitor.sv
// -----------------------------------------------------------------------------
// tmr_error_monitor
//
// Checking end of a triplicated signal path. Votes the three copies of a
// WIDTH-bit bus bitwise, registers the majority, flags which copies disagreed,
// counts per-lane error cycles with saturating counters, and holds the most
// recent unread error event in a one-entry register with a valid/ready
// readout. A sticky flag records events dropped while the register was full.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset, overrides everything
//   inA/B/C    in   WIDTH   the three copies of the triplicated bus
//   clr        in   synchronous clear of the counters and evt_lost
//   voted      out  WIDTH   registered bitwise majority
//   errA/B/C   out  registered: that copy differed from the majority last sample
//   cntA/B/C   out  CNT_WIDTH  saturating count of error cycles per copy
//   evt_valid  out  event register holds an unread event
//   evt_ready  in   consumer accepts the held event
//   evt_lanes  out  3       {C,B,A} lanes in error for the held event
//   evt_mask   out  WIDTH   bits where any lane disagreed for the held event
//   evt_lost   out  sticky: an event was dropped because the register was full
// -----------------------------------------------------------------------------
module tmr_error_monitor #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     inA,
  input  logic [WIDTH-1:0]     inB,
  input  logic [WIDTH-1:0]     inC,
  input  logic                 clr,
  output logic [WIDTH-1:0]     voted,
  output logic                 errA,
  output logic                 errB,
  output logic                 errC,
  output logic [CNT_WIDTH-1:0] cntA,
  output logic [CNT_WIDTH-1:0] cntB,
  output logic [CNT_WIDTH-1:0] cntC,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [2:0]           evt_lanes,
  output logic [WIDTH-1:0]     evt_mask,
  output logic                 evt_lost
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } evt_state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  evt_state_t       state;
  logic [WIDTH-1:0] maj;
  logic [WIDTH-1:0] mask_a;
  logic [WIDTH-1:0] mask_b;
  logic [WIDTH-1:0] mask_c;
  logic             err_a;
  logic             err_b;
  logic             err_c;
  logic             err_any;

  // Vote and mismatch detection. At most one lane can disagree on any given
  // bit, but different bits may implicate different lanes.
  always_comb begin
    maj     = (inA & inB) | (inA & inC) | (inB & inC);
    mask_a  = inA ^ maj;
    mask_b  = inB ^ maj;
    mask_c  = inC ^ maj;
    err_a   = |mask_a;
    err_b   = |mask_b;
    err_c   = |mask_c;
    err_any = err_a | err_b | err_c;
  end

  assign evt_valid = (state == FULL);

  // NOTE: every state register uses non-blocking assignment so all of them
  // update together from the same pre-edge values; blocking here would let
  // later statements see already-updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      voted     <= '0;
      errA      <= 1'b0;
      errB      <= 1'b0;
      errC      <= 1'b0;
      cntA      <= '0;
      cntB      <= '0;
      cntC      <= '0;
      state     <= EMPTY;
      evt_lanes <= '0;
      evt_mask  <= '0;
      evt_lost  <= 1'b0;
    end else begin
      voted <= maj;
      errA  <= err_a;
      errB  <= err_b;
      errC  <= err_c;

      // Counters stick at all-ones; clr takes priority over an increment.
      if (clr)                          cntA <= '0;
      else if (err_a && cntA != CNT_MAX) cntA <= cntA + 1'b1;
      if (clr)                          cntB <= '0;
      else if (err_b && cntB != CNT_MAX) cntB <= cntB + 1'b1;
      if (clr)                          cntC <= '0;
      else if (err_c && cntC != CNT_MAX) cntC <= cntC + 1'b1;

      // A pop and a push in the same cycle replace the event without loss.
      // The register only drops an event when it is full and not being read.
      unique case (state)
        EMPTY: begin
          if (err_any) begin
            evt_lanes <= {err_c, err_b, err_a};
            evt_mask  <= mask_a | mask_b | mask_c;
            state     <= FULL;
          end
        end
        FULL: begin
          if (evt_ready) begin
            if (err_any) begin
              evt_lanes <= {err_c, err_b, err_a};
              evt_mask  <= mask_a | mask_b | mask_c;
            end else begin
              state <= EMPTY;
            end
          end
        end
        default: state <= EMPTY;
      endcase

      // clr wins over a loss detected in the same cycle.
      if (clr)
        evt_lost <= 1'b0;
      else if (state == FULL && !evt_ready && err_any)
        evt_lost <= 1'b1;
    end
  end

endmodule

// File: doc/tmr_error_monitor.md
# tmr_error_monitor

Checking end of a triplicated signal path: it takes the three copies of a WIDTH-bit bus and produces a registered majority-voted bus. It also reports which copies disagreed with the vote. Per-lane saturating error counters and a one-entry event register with a valid/ready readout let slow-control logic find and count single-event upsets in the triplicated registers feeding it.

## Interface
- WIDTH, 8, width of each triplicated bus copy
- CNT_WIDTH, 16, width of each per-lane error counter
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- inA  in  WIDTH  copy A of the triplicated bus
- inB  in  WIDTH  copy B
- inC  in  WIDTH  copy C
- clr  in  1  synchronous clear of counters and evt_lost
- voted  out  WIDTH  registered bitwise majority of inA/inB/inC
- errA  out  1  registered: copy A differed from majority in ≥1 bit last sample
- errB  out  1  same for copy B
- errC  out  1  same for copy C
- cntA  out  CNT_WIDTH  saturating count of cycles with errA condition
- cntB  out  CNT_WIDTH  same for copy B
- cntC  out  CNT_WIDTH  same for copy C
- evt_valid  out  1  event register holds an unread event
- evt_ready  in  1  consumer accepts event
- evt_lanes  out  3  {C,B,A} lanes in error for the held event
- evt_mask  out  WIDTH  bits where any lane disagreed, for the held event
- evt_lost  out  1  sticky: an event was dropped because the register was full

## Operation
- Combinational vote per bit: m = A&B | A&C | B&C.
- Per-lane mismatch masks: mA = inA^m, mB = inB^m, mC = inC^m.
- Per bit, at most one lane can differ. Different bits may implicate different lanes, so any combination of lanes can flag in the same cycle.
- Lane error condition: eX = |mX. Cycle error condition: e = eA|eB|eC.
- Every cycle, register the following:
  - voted <= m
  - errX <= eX
  - if eX, cntX <= cntX+1, saturating at all-ones (never wraps)
- Event register has two states: EMPTY and FULL.
  - EMPTY, e=1: capture evt_lanes={eC,eB,eA} and evt_mask=mA|mB|mC. Go to FULL.
  - FULL, evt_ready=1, e=0: go to EMPTY.
  - FULL, evt_ready=1, e=1: capture the new event and stay FULL. Pop and push in the same cycle loses nothing.
  - FULL, evt_ready=0, e=1: keep the old event and set evt_lost=1.
  - evt_valid = (state==FULL).
- evt_ready while EMPTY has no effect.
- clr=1 behaviour:
  - cntA/B/C <= 0 and evt_lost <= 0; clr wins over a same-cycle increment or loss.
  - voted, errX and the event register are unaffected; an event can still be captured in a clr cycle.
- rst=1 behaviour:
  - every register is cleared, overriding clr and all other inputs.
  - reset values: voted=0, errA/B/C=0, cntA/B/C=0, state EMPTY, evt_valid=0, evt_lanes=0, evt_mask=0, evt_lost=0.
  - rst mid-operation discards any held event without asserting evt_lost.

## Timing
- Inputs sampled at edge N.
  - voted, errX and cntX reflect that sample after edge N (latency 1).
  - evt_valid rises after edge N.
- Handshake: transfer occurs at a rising edge with evt_valid=1 and evt_ready=1.
  - While evt_valid=1 and evt_ready=0, evt_lanes and evt_mask hold stable.
- evt_valid has no combinational dependency on evt_ready. There are no combinational input-to-output paths.
- Counter saturation: at all-ones, a further error leaves the value unchanged, on the same edge.
- Back-to-back errors with evt_ready held at 1 produce one event per cycle and no loss.

## Test plan
- **Reset:** rst=1 for 2 cycles with random inputs. Every output is 0. Release with inA=inB=inC=8'h5A: voted=8'h5A after one edge, errX=0, evt_valid=0.
- **Single upset:** inA=8'h5A^8'h01, inB=inC=8'h5A for one cycle, evt_ready=0. Next cycle: voted=8'h5A, errA=1, cntA=1, evt_valid=1, evt_lanes=3'b001, evt_mask=8'h01. Event holds until evt_ready=1.
- **Multi-lane:** inA bit0 flipped, inC bit7 flipped, same cycle. evt_lanes=3'b101, evt_mask=8'h81, cntA and cntC each +1, cntB unchanged.
- **Loss vs pop:** with FULL and evt_ready=0, inject an error, then evt_lost=1 and the old event is retained. Repeat with evt_ready=1: the new event replaces the old one and evt_lost stays 0. Then clr=1 clears evt_lost and the counters.
- **Saturation:** CNT_WIDTH=4, hold inB wrong for 20 cycles. cntB reaches 4'hF and stays there. clr with a same-cycle error gives cntB=0.
- **Reset mid-event:** FULL with evt_ready=0, assert rst. Next cycle evt_valid=0 and evt_lost=0.
